// File: rtl/local_net_iface_pkg.sv
// Shared types and helpers for the local network interface.
// Holds the injection FSM encoding, the default link width and the link transfer rule.
package local_net_iface_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } inj_state_e;

  localparam int DATA_SIZE_DEF = 8;

  // A word crosses a fill/empty link on the edge where both sides agree.
  function automatic logic link_xfer(input logic fill, input logic empty);
    return fill & empty;
  endfunction

endpackage

// File: rtl/local_net_iface_sync_fifo.sv
// Synchronous FIFO with read/write pointers and an occupancy count.
// Push is ignored when full and pop is ignored when empty.
module local_net_iface_sync_fifo #(
  parameter int data_size = 8,
  parameter int depth     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [data_size-1:0] din_i,
  output logic [data_size-1:0] dout_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [data_size-1:0] mem_q [depth];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full_o  = (cnt_q == CW'(depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == AW'(depth - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(depth - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/local_net_iface.sv
// Network interface between a processing element and a router local port.
// Injection FIFO plus offer FSM toward the router, ejection FIFO toward the PE, transfer counters.
module local_net_iface
  import local_net_iface_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF,
  parameter int inj_depth = 4,
  parameter int ej_depth  = 4,
  parameter int cnt_size  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pe_valid_i,
  input  logic [data_size-1:0] pe_data_i,
  output logic                 pe_ready_o,
  output logic                 pe_valid_o,
  output logic [data_size-1:0] pe_data_o,
  input  logic                 pe_ready_i,
  output logic                 r_fill_o,
  output logic [data_size-1:0] r_data_o,
  input  logic                 r_empty_i,
  input  logic                 r_fill_i,
  input  logic [data_size-1:0] r_data_i,
  output logic                 r_empty_o,
  output logic [cnt_size-1:0]  tx_cnt_o,
  output logic [cnt_size-1:0]  rx_cnt_o
);

  localparam int OW = $clog2(inj_depth + 1);

  inj_state_e           state_q;
  logic [OW-1:0]        inj_occ_q, inj_occ_d;
  logic [cnt_size-1:0]  tx_cnt_q, rx_cnt_q;

  logic                 inj_push, inj_pop, inj_full, inj_empty, inj_more;
  logic [data_size-1:0] inj_head;
  logic                 ej_push, ej_pop, ej_full, ej_empty;
  logic [data_size-1:0] ej_head;

  local_net_iface_sync_fifo #(
    .data_size (data_size),
    .depth     (inj_depth)
  ) u_inj_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inj_push),
    .pop_i   (inj_pop),
    .din_i   (pe_data_i),
    .dout_o  (inj_head),
    .full_o  (inj_full),
    .empty_o (inj_empty)
  );

  local_net_iface_sync_fifo #(
    .data_size (data_size),
    .depth     (ej_depth)
  ) u_ej_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ej_push),
    .pop_i   (ej_pop),
    .din_i   (r_data_i),
    .dout_o  (ej_head),
    .full_o  (ej_full),
    .empty_o (ej_empty)
  );

  assign pe_ready_o = ~inj_full;
  assign inj_push   = pe_valid_i & pe_ready_o;
  assign r_fill_o   = (state_q == OFFER);
  assign r_data_o   = r_fill_o ? inj_head : '0;
  assign inj_pop    = link_xfer(r_fill_o, r_empty_i);

  // Staying in OFFER after a pop needs to know whether a word is left behind,
  // which full/empty alone cannot tell, so occupancy is tracked here.
  assign inj_more = inj_push | (inj_occ_q > OW'(1));

  always_comb begin
    inj_occ_d = inj_occ_q;
    case ({inj_push, inj_pop})
      2'b10:   inj_occ_d = inj_occ_q + OW'(1);
      2'b01:   inj_occ_d = inj_occ_q - OW'(1);
      default: inj_occ_d = inj_occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inj_occ_q <= '0;
    end else begin
      inj_occ_q <= inj_occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!inj_empty) begin
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (inj_pop) begin
            tx_cnt_q <= tx_cnt_q + cnt_size'(1);
            if (!inj_more) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r_empty_o  = ~ej_full;
  assign ej_push    = link_xfer(r_fill_i, r_empty_o);
  assign pe_valid_o = ~ej_empty;
  assign ej_pop     = pe_valid_o & pe_ready_i;
  assign pe_data_o  = pe_valid_o ? ej_head : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt_q <= '0;
    end else if (ej_push) begin
      rx_cnt_q <= rx_cnt_q + cnt_size'(1);
    end
  end

  assign tx_cnt_o = tx_cnt_q;
  assign rx_cnt_o = rx_cnt_q;

endmodule

// File: tb/tb_local_net_iface.sv
// Scoreboard bench for local_net_iface: accepted words are queued on each side
// and compared in order when the DUT hands them on; directed checks cover timing.
module tb_local_net_iface;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pe_valid_i;
  logic [DW-1:0] pe_data_i;
  logic          pe_ready_o;
  logic          pe_valid_o;
  logic [DW-1:0] pe_data_o;
  logic          pe_ready_i;
  logic          r_fill_o;
  logic [DW-1:0] r_data_o;
  logic          r_empty_i;
  logic          r_fill_i;
  logic [DW-1:0] r_data_i;
  logic          r_empty_o;
  logic [CW-1:0] tx_cnt_o;
  logic [CW-1:0] rx_cnt_o;

  local_net_iface #(
    .data_size (DW),
    .inj_depth (4),
    .ej_depth  (4),
    .cnt_size  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pe_valid_i (pe_valid_i),
    .pe_data_i  (pe_data_i),
    .pe_ready_o (pe_ready_o),
    .pe_valid_o (pe_valid_o),
    .pe_data_o  (pe_data_o),
    .pe_ready_i (pe_ready_i),
    .r_fill_o   (r_fill_o),
    .r_data_o   (r_data_o),
    .r_empty_i  (r_empty_i),
    .r_fill_i   (r_fill_i),
    .r_data_i   (r_data_i),
    .r_empty_o  (r_empty_o),
    .tx_cnt_o   (tx_cnt_o),
    .rx_cnt_o   (rx_cnt_o)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] inj_q[$];
  logic [DW-1:0] ej_q[$];
  int            tx_seen = 0;
  int            rx_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are stable at the falling edge, so handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pe_valid_i && pe_ready_o) inj_q.push_back(pe_data_i);
      if (r_fill_i && r_empty_o) ej_q.push_back(r_data_i);
      if (r_fill_o && r_empty_i) begin
        if (inj_q.size() == 0) check("inj_unexpected_word", {24'd0, r_data_o}, 32'hFFFF_FFFF);
        else check("inj_order", {24'd0, r_data_o}, {24'd0, inj_q.pop_front()});
        tx_seen++;
      end
      if (pe_valid_o && pe_ready_i) begin
        if (ej_q.size() == 0) check("ej_unexpected_word", {24'd0, pe_data_o}, 32'hFFFF_FFFF);
        else check("ej_order", {24'd0, pe_data_o}, {24'd0, ej_q.pop_front()});
        rx_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pe_valid_i = 1'b0;
    pe_data_i  = '0;
    pe_ready_i = 1'b0;
    r_empty_i  = 1'b0;
    r_fill_i   = 1'b0;
    r_data_i   = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pe_valid_i = 1'($urandom);
      pe_data_i  = DW'($urandom);
      pe_ready_i = 1'($urandom);
      r_empty_i  = 1'($urandom);
      r_fill_i   = 1'($urandom);
      r_data_i   = DW'($urandom);
      tick();
    end
    check("rst_r_fill", {31'd0, r_fill_o}, 32'd0);
    check("rst_r_data", {24'd0, r_data_o}, 32'd0);
    check("rst_pe_ready", {31'd0, pe_ready_o}, 32'd1);
    check("rst_pe_valid", {31'd0, pe_valid_o}, 32'd0);
    check("rst_pe_data", {24'd0, pe_data_o}, 32'd0);
    check("rst_r_empty", {31'd0, r_empty_o}, 32'd1);
    check("rst_tx_cnt", {28'd0, tx_cnt_o}, 32'd0);
    check("rst_rx_cnt", {28'd0, rx_cnt_o}, 32'd0);
    idle_inputs();
    inj_q.delete();
    ej_q.delete();
    tx_seen = 0;
    rx_seen = 0;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int c;
    pe_valid_i = 1'b0;
    r_fill_i   = 1'b0;
    pe_ready_i = 1'b1;
    r_empty_i  = 1'b1;
    c = 0;
    while ((inj_q.size() != 0 || ej_q.size() != 0 || r_fill_o || pe_valid_o) && c < 60) begin
      tick();
      c++;
    end
    check({tag, "_drain_inj"}, inj_q.size(), 32'd0);
    check({tag, "_drain_ej"}, ej_q.size(), 32'd0);
    check({tag, "_drain_timeout"}, {31'd0, (c >= 60)}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    do_reset();

    // Single inject: offered one cycle after the push edge, counted on the next.
    pe_valid_i = 1'b1;
    pe_data_i  = 8'hA5;
    r_empty_i  = 1'b1;
    tick();
    pe_valid_i = 1'b0;
    check("single_no_fill_yet", {31'd0, r_fill_o}, 32'd0);
    tick();
    check("single_fill", {31'd0, r_fill_o}, 32'd1);
    check("single_data", {24'd0, r_data_o}, 32'hA5);
    tick();
    check("single_tx_cnt", {28'd0, tx_cnt_o}, 32'd1);
    check("single_fill_drop", {31'd0, r_fill_o}, 32'd0);

    // Back-pressure from the router fills the injection FIFO.
    do_reset();
    r_empty_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pe_valid_i = 1'b1;
      pe_data_i  = DW'(i);
      tick();
    end
    pe_valid_i = 1'b0;
    check("bp_ready_low", {31'd0, pe_ready_o}, 32'd0);
    tick();
    check("bp_hold_fill", {31'd0, r_fill_o}, 32'd1);
    check("bp_hold_data", {24'd0, r_data_o}, 32'h01);
    r_empty_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("bp_seq_fill", {31'd0, r_fill_o}, 32'd1);
      check("bp_seq_data", {24'd0, r_data_o}, i);
      tick();
    end
    check("bp_idle", {31'd0, r_fill_o}, 32'd0);
    check("bp_tx_cnt", {28'd0, tx_cnt_o}, 32'd4);
    check("bp_ready_back", {31'd0, pe_ready_o}, 32'd1);

    // Ejection FIFO fills while the PE stalls; the fifth word waits.
    do_reset();
    r_fill_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      r_data_i = 8'h10 + DW'(k);
      check("ej_r_empty", {31'd0, r_empty_o}, (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("ej_rx_cnt_full", {28'd0, rx_cnt_o}, 32'd4);
    pe_ready_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      logic took;
      check("ej_valid", {31'd0, pe_valid_o}, 32'd1);
      check("ej_data", {24'd0, pe_data_o}, 32'h10 + j);
      took = r_fill_i & r_empty_o;
      tick();
      if (took) r_fill_i = 1'b0;
    end
    check("ej_empty_after", {31'd0, pe_valid_o}, 32'd0);
    check("ej_rx_cnt", {28'd0, rx_cnt_o}, 32'd5);

    // Reset while a word is being offered: it is dropped and never counted.
    do_reset();
    pe_valid_i = 1'b1;
    pe_data_i  = 8'h77;
    tick();
    pe_valid_i = 1'b0;
    tick();
    check("midrst_offer_fill", {31'd0, r_fill_o}, 32'd1);
    check("midrst_offer_data", {24'd0, r_data_o}, 32'h77);
    rst_n = 1'b0;
    inj_q.delete();
    tick();
    check("midrst_fill", {31'd0, r_fill_o}, 32'd0);
    check("midrst_tx_cnt", {28'd0, tx_cnt_o}, 32'd0);
    check("midrst_ready", {31'd0, pe_ready_o}, 32'd1);
    rst_n = 1'b1;
    r_empty_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("midrst_no_xfer_fill", {31'd0, r_fill_o}, 32'd0);
    check("midrst_no_xfer_cnt", {28'd0, tx_cnt_o}, 32'd0);

    // Counter wrap: 17 injected words leave a 4-bit counter at 1.
    do_reset();
    r_empty_i = 1'b1;
    begin
      int acc;
      int c;
      acc = 0;
      c = 0;
      while (acc < 17 && c < 200) begin
        pe_valid_i = 1'b1;
        pe_data_i  = DW'($urandom);
        if (pe_ready_o) acc++;
        tick();
        c++;
      end
      check("wrap_push_timeout", {31'd0, (c >= 200)}, 32'd0);
    end
    drain("wrap");
    check("wrap_tx_seen", tx_seen, 32'd17);
    check("wrap_tx_cnt", {28'd0, tx_cnt_o}, 32'd1);

    // Concurrent traffic: full rate, then random handshakes on every link.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      pe_valid_i = 1'b1;
      pe_data_i  = DW'($urandom);
      r_empty_i  = 1'b1;
      r_fill_i   = 1'b1;
      r_data_i   = DW'($urandom);
      pe_ready_i = 1'b1;
      tick();
    end
    for (int i = 0; i < 150; i++) begin
      pe_valid_i = 1'($urandom);
      pe_data_i  = DW'($urandom);
      r_empty_i  = 1'($urandom);
      r_fill_i   = 1'($urandom);
      r_data_i   = DW'($urandom);
      pe_ready_i = 1'($urandom);
      tick();
    end
    drain("stream");
    check("stream_tx_cnt", {28'd0, tx_cnt_o}, tx_seen % 16);
    check("stream_rx_cnt", {28'd0, rx_cnt_o}, rx_seen % 16);
    check("stream_tx_moved", {31'd0, (tx_seen >= 100)}, 32'd1);
    check("stream_rx_moved", {31'd0, (rx_seen >= 100)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
